sigma_cpu: RTL and testbench
============================

// Module: sigma_cpu
// PURPOSE
// - Multi-cycle subset Xerox Sigma CPU core: fetches 32-bit big-endian ([0:31]) instructions from a word memory, executes them, halts on WAIT.
// - Sits between the clock generator and a word RAM with combinational read data and byte-lane write enables.
// - Memory writes happen on the clock edge that ends the execute cycle.
// PARAMETERS
// - RESET_PC   17'h00000   word address of first fetch after reset
// - CLK_PERIOD 10          clock sub-module period in ns (simulation only)
// PORTS
// - reset       in   1      asynchronous, active-low reset; clock is the single clock
// - clock       in   1      rising-edge clock
// - data_in     in   32     memory read data [0:31], combinational from address
// - address     out  17     word address [15:31]
// - data_out    out  32     memory write data [0:31]
// - wr_en       out  4      byte-lane write strobes [0:3], bit0 = byte [0:7]
// BEHAVIOUR
// - State: P (17b program counter), R0..R15 (32b), CC (4b, CC1..CC4), instruction reg, register `phase`.
// - `phase` values: PCP1, PH1, PH2, PCP2. Both `phase` and the named constants are hierarchically visible (benches poll phase == PCP2).
// - Reset (reset=0, async): phase=PCP1, P=RESET_PC, CC=0, R0..R15=0, address=0, data_out=0, wr_en=4'b0000.
// - PCP1 -> PH1 on the first clock edge after reset release.
// - PH1 (fetch): address=P; edge latches data_in into instruction reg, P<=P+1, -> PH2.
// - PH2 (execute): one cycle, -> PH1 unless halting. Every instruction takes 2 cycles.
// - Instruction fields: [0] indirect (ignored), [1:7] opcode, [8:11] R, [12:14] X, [15:31] address.
// - EA = addr + (X!=0 ? Rx[15:31] : 0), mod 2^17.
// - Immediate = sign-extended [12:31].
// - Opcodes:
//   - 0x22 LI:  R <= imm.
//   - 0x20 AI:  R <= R + imm.
//   - 0x30 AW:  R <= R + mem[EA].
//   - 0x32 LW:  R <= mem[EA]; address=EA during PH2.
//   - 0x35 STW: address=EA, data_out=R, wr_en=1111 during PH2 only.
//   - 0x68 BCR: P <= EA if (CC[1:4] & R)==0; R=0 is an unconditional branch.
//   - 0x69 BCS: P <= EA if (CC & R)!=0.
//   - 0x2E WAIT: -> PCP2.
// - CC rules:
//   - LI, LW, AI, AW: CC3 = result>0, CC4 = result<0.
//   - AI, AW additionally: CC1 = carry out of bit 0, CC2 = signed overflow.
//   - STW and branches leave CC unchanged.
// - Add arithmetic: 32-bit two's complement, wraps; overflow sets CC2 only, no trap.
// - Any other opcode: halt to PCP2 (same as WAIT).
// - PCP2: holds all state, wr_en=0000, address=P; only reset exits.
// - wr_en is 0000 in every cycle except the PH2 of STW.
// - P wraps 17'h1FFFF -> 0.
// - Branch target taken in PH2 overrides the PH1 increment.
// - Reset asserted mid-instruction aborts it; an in-flight STW write is suppressed because wr_en clears asynchronously.
// STRUCTURE
// - Shared package sigma_pkg: opcode constants, phase encodings (PCP1/PH1/PH2/PCP2), instruction field slice helpers.
// - One sub-module, sigma_clock (CLK_PERIOD, output clock, 50% duty, starts low), for simulation.
// - Register file and datapath stay inline in sigma_cpu.
// TESTING
// - Reset release, mem[0]=0x2E000000 (WAIT) -> PH1 fetch at address 0, PCP2 reached on the 3rd edge, wr_en stays 0000.
// - LI R1,5; AI R1,-7; STW R1,0x40; WAIT -> mem[0x40]=0xFFFFFFFE, CC=0001.
// - LW R2,0x50 (mem 0x7FFFFFFF); AW R2,0x51 (mem 1); STW R2,0x52 -> mem[0x52]=0x80000000, CC2=1, CC4=1.
// - Loop: LI R3,3; AI R3,-1; BCS 2,back(R=2 tests CC3); STW R3,0x60; WAIT -> mem[0x60]=0, 3 loop passes.
// - Index: LI R4,2; LW R5,0x70,X=4 (mem[0x72]=0xA5A5A5A5) -> R5=0xA5A5A5A5.
// - Assert reset during the PH2 of STW -> no write occurs; phase=PCP1, outputs zero immediately.
// - Opcode 0x7F executed -> PCP2 entered, memory unchanged.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared definitions for the Sigma subset core: phase encodings, opcodes
// and instruction field slicing.
package sigma_pkg;

  typedef enum logic [1:0] {
    PCP1 = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    PCP2 = 2'd3
  } phase_t;

  localparam logic [6:0] OP_AI   = 7'h20;
  localparam logic [6:0] OP_LI   = 7'h22;
  localparam logic [6:0] OP_WAIT = 7'h2E;
  localparam logic [6:0] OP_AW   = 7'h30;
  localparam logic [6:0] OP_LW   = 7'h32;
  localparam logic [6:0] OP_STW  = 7'h35;
  localparam logic [6:0] OP_BCR  = 7'h68;
  localparam logic [6:0] OP_BCS  = 7'h69;

  // Fields are numbered big-endian: Sigma bit n lives at vector bit 31-n.
  // The indirect bit [0] is never used, so the slices take bits 30:0 only.
  function automatic logic [6:0] f_op(input logic [30:0] w);
    return w[30:24];
  endfunction

  function automatic logic [3:0] f_r(input logic [30:0] w);
    return w[23:20];
  endfunction

  function automatic logic [2:0] f_x(input logic [30:0] w);
    return w[19:17];
  endfunction

  function automatic logic [16:0] f_addr(input logic [30:0] w);
    return w[16:0];
  endfunction

  function automatic logic [31:0] f_imm(input logic [30:0] w);
    return {{12{w[19]}}, w[19:0]};
  endfunction

  // Returns {CC3, CC4}: result strictly positive / negative.
  function automatic logic [1:0] f_cc_sign(input logic [31:0] v);
    return {(~v[31]) & (v != 32'd0), v[31]};
  endfunction

endpackage

// File: rtl/sigma_cpu.sv
// Multi-cycle Sigma subset core: PH1 fetches, PH2 executes, WAIT or an
// unknown opcode parks the core in PCP2 until reset.
module sigma_cpu
  import sigma_pkg::*;
#(
  parameter logic [16:0] RESET_PC = 17'h00000
) (
  input  logic        reset,
  input  logic        clock,
  input  logic [31:0] data_in,
  output logic [16:0] address,
  output logic [31:0] data_out,
  output logic [3:0]  wr_en
);

  phase_t      phase;
  phase_t      phase_nxt_s;
  logic [16:0] p_r;
  logic [16:0] ea_r;
  logic [30:0] ir_r;
  logic [31:0] regs_r [16];
  logic [3:0]  cc_r;
  logic [16:0] address_r;
  logic [31:0] data_out_r;
  logic [3:0]  wr_en_r;

  logic [6:0]  fetch_op_s;
  logic [2:0]  fetch_x_s;
  logic [16:0] fetch_ea_s;
  logic        fetch_mem_s;

  logic [6:0]  exec_op_s;
  logic [3:0]  exec_r_s;
  logic [31:0] rval_s;
  logic [31:0] addend_s;
  logic [32:0] sum_s;
  logic        ovf_s;
  logic [31:0] result_s;
  logic        wr_reg_s;
  logic        branch_s;
  logic        halt_s;
  logic [3:0]  cc_nxt_s;
  logic [16:0] p_nxt_s;

  assign address  = address_r;
  assign data_out = data_out_r;
  assign wr_en    = wr_en_r;

  // Decode the word arriving in PH1 so PH2 outputs can be registered ahead.
  always_comb begin
    fetch_op_s = f_op(data_in[30:0]);
    fetch_x_s  = f_x(data_in[30:0]);
    if (fetch_x_s != 3'd0) begin
      fetch_ea_s = f_addr(data_in[30:0]) + regs_r[{1'b0, fetch_x_s}][16:0];
    end else begin
      fetch_ea_s = f_addr(data_in[30:0]);
    end
    if ((fetch_op_s == OP_LW) || (fetch_op_s == OP_AW) || (fetch_op_s == OP_STW)) begin
      fetch_mem_s = 1'b1;
    end else begin
      fetch_mem_s = 1'b0;
    end
  end

  // Execute-stage datapath: adder, result select, CC update and branch test.
  always_comb begin
    exec_op_s = f_op(ir_r);
    exec_r_s  = f_r(ir_r);
    rval_s    = regs_r[exec_r_s];
    if (exec_op_s == OP_AW) begin
      addend_s = data_in;
    end else begin
      addend_s = f_imm(ir_r);
    end
    sum_s    = {1'b0, rval_s} + {1'b0, addend_s};
    ovf_s    = (rval_s[31] == addend_s[31]) && (sum_s[31] != rval_s[31]);
    result_s = sum_s[31:0];
    wr_reg_s = 1'b0;
    branch_s = 1'b0;
    halt_s   = 1'b0;
    cc_nxt_s = cc_r;
    case (exec_op_s)
      OP_LI: begin
        result_s      = f_imm(ir_r);
        wr_reg_s      = 1'b1;
        cc_nxt_s[1:0] = f_cc_sign(f_imm(ir_r));
      end
      OP_LW: begin
        result_s      = data_in;
        wr_reg_s      = 1'b1;
        cc_nxt_s[1:0] = f_cc_sign(data_in);
      end
      OP_AI, OP_AW: begin
        wr_reg_s = 1'b1;
        cc_nxt_s = {sum_s[32], ovf_s, f_cc_sign(sum_s[31:0])};
      end
      OP_STW:  wr_reg_s = 1'b0;
      OP_BCR:  branch_s = ((cc_r & exec_r_s) == 4'd0);
      OP_BCS:  branch_s = ((cc_r & exec_r_s) != 4'd0);
      OP_WAIT: halt_s   = 1'b1;
      default: halt_s   = 1'b1;
    endcase
    if (branch_s) begin
      p_nxt_s = ea_r;
    end else begin
      p_nxt_s = p_r;
    end
  end

  // Phase sequencing.
  always_comb begin
    phase_nxt_s = phase;
    case (phase)
      PCP1: phase_nxt_s = PH1;
      PH1:  phase_nxt_s = PH2;
      PH2: begin
        if (halt_s) begin
          phase_nxt_s = PCP2;
        end else begin
          phase_nxt_s = PH1;
        end
      end
      PCP2:    phase_nxt_s = PCP2;
      default: phase_nxt_s = PCP1;
    endcase
  end

  // Phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= PCP1;
    end else begin
      phase <= phase_nxt_s;
    end
  end

  // Architectural state and registered memory-side outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_r        <= RESET_PC;
      ea_r       <= 17'd0;
      ir_r       <= 31'd0;
      cc_r       <= 4'd0;
      address_r  <= 17'd0;
      data_out_r <= 32'd0;
      wr_en_r    <= 4'b0000;
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else begin
      case (phase)
        PCP1: begin
          address_r  <= p_r;
          data_out_r <= 32'd0;
          wr_en_r    <= 4'b0000;
        end
        PH1: begin
          ir_r <= data_in[30:0];
          p_r  <= p_r + 17'd1;
          ea_r <= fetch_ea_s;
          if (fetch_mem_s) begin
            address_r <= fetch_ea_s;
          end else begin
            address_r <= p_r + 17'd1;
          end
          if (fetch_op_s == OP_STW) begin
            data_out_r <= regs_r[f_r(data_in[30:0])];
            wr_en_r    <= 4'b1111;
          end else begin
            data_out_r <= 32'd0;
            wr_en_r    <= 4'b0000;
          end
        end
        PH2: begin
          if (wr_reg_s) begin
            regs_r[exec_r_s] <= result_s;
          end
          cc_r       <= cc_nxt_s;
          p_r        <= p_nxt_s;
          address_r  <= p_nxt_s;
          data_out_r <= 32'd0;
          wr_en_r    <= 4'b0000;
        end
        PCP2: begin
          address_r  <= p_r;
          data_out_r <= 32'd0;
          wr_en_r    <= 4'b0000;
        end
        default: begin
          wr_en_r <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: a table of small programs run to PCP2,
// plus hand sequences for reset release and reset during a store.
module tb_sigma_cpu;
  import sigma_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic [16:0] address;
  logic [31:0] data_out;
  logic [3:0]  wr_en;

  logic [31:0] mem [0:1023];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stray_wr = 0;
  bit          track_wr = 1'b0;

  sigma_clock #(.CLK_PERIOD(10)) u_clk (.clock(clock));

  sigma_cpu #(.RESET_PC(17'h00000)) dut (
    .reset    (reset),
    .clock    (clock),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out),
    .wr_en    (wr_en)
  );

  assign data_in = mem[address[9:0]];

  always @(posedge clock) begin
    if (wr_en[0]) mem[address[9:0]][31:24] <= data_out[31:24];
    if (wr_en[1]) mem[address[9:0]][23:16] <= data_out[23:16];
    if (wr_en[2]) mem[address[9:0]][15:8]  <= data_out[15:8];
    if (wr_en[3]) mem[address[9:0]][7:0]   <= data_out[7:0];
  end

  always @(negedge clock) begin
    if (track_wr && (wr_en != 4'b0000)) stray_wr++;
  end

  typedef struct {
    string            name;
    logic [5:0][31:0] prog;
    logic [16:0]      pa0;
    logic [31:0]      pv0;
    logic [16:0]      pa1;
    logic [31:0]      pv1;
    logic [16:0]      ca;
    logic [31:0]      cv;
    logic [3:0]       ecc;
    int               ri;
    logic [31:0]      rv;
    int               edges;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [5:0][31:0] prog);
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
  endtask

  task automatic start_from_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    load(v.prog);
    mem[v.pa0[9:0]] = v.pv0;
    mem[v.pa1[9:0]] = v.pv1;
    start_from_reset();
    edges = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock);
      #1;
      edges++;
      if (dut.phase == PCP2) break;
    end
    check({v.name, " edges"}, 32'(edges), 32'(v.edges));
    check({v.name, " phase"}, 32'(dut.phase), 32'(PCP2));
    check({v.name, " mem"}, mem[v.ca[9:0]], v.cv);
    check({v.name, " cc"}, 32'(dut.cc_r), 32'(v.ecc));
    check({v.name, " reg"}, dut.regs_r[v.ri], v.rv);
    @(negedge clock);
    check({v.name, " pcp2 wr_en"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    vecs[0] = '{name:"li_ai_stw", prog:{32'h0, 32'h0, 32'h2E000000, 32'h35100040, 32'h201FFFF9, 32'h22100005},
                pa0:17'h100, pv0:32'h0, pa1:17'h101, pv1:32'h0,
                ca:17'h40, cv:32'hFFFFFFFE, ecc:4'b0001, ri:1, rv:32'hFFFFFFFE, edges:9};
    vecs[1] = '{name:"lw_aw_ovf", prog:{32'h0, 32'h0, 32'h2E000000, 32'h35200052, 32'h30200051, 32'h32200050},
                pa0:17'h50, pv0:32'h7FFFFFFF, pa1:17'h51, pv1:32'h00000001,
                ca:17'h52, cv:32'h80000000, ecc:4'b0101, ri:2, rv:32'h80000000, edges:9};
    vecs[2] = '{name:"bcs_loop", prog:{32'h0, 32'h2E000000, 32'h35300060, 32'h69200001, 32'h203FFFFF, 32'h22300003},
                pa0:17'h60, pv0:32'h55555555, pa1:17'h100, pv1:32'h0,
                ca:17'h60, cv:32'h00000000, ecc:4'b1000, ri:3, rv:32'h0, edges:19};
    vecs[3] = '{name:"indexed_lw", prog:{32'h0, 32'h0, 32'h0, 32'h2E000000, 32'h32580070, 32'h22400002},
                pa0:17'h72, pv0:32'hA5A5A5A5, pa1:17'h70, pv1:32'h0BADF00D,
                ca:17'h72, cv:32'hA5A5A5A5, ecc:4'b0001, ri:5, rv:32'hA5A5A5A5, edges:7};
    vecs[4] = '{name:"bad_opcode", prog:{32'h0, 32'h0, 32'h0, 32'h0, 32'h35000080, 32'h7F000000},
                pa0:17'h80, pv0:32'h12345678, pa1:17'h100, pv1:32'h0,
                ca:17'h80, cv:32'h12345678, ecc:4'b0000, ri:0, rv:32'h0, edges:3};
    vecs[5] = '{name:"bcr_uncond", prog:{32'h0, 32'h0, 32'h2E000000, 32'h35600090, 32'h68000003, 32'h22600001},
                pa0:17'h90, pv0:32'hDEADBEEF, pa1:17'h100, pv1:32'h0,
                ca:17'h90, cv:32'hDEADBEEF, ecc:4'b0010, ri:6, rv:32'h00000001, edges:7};

    // Reset state and the WAIT-only program, edge by edge.
    load({32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2E000000});
    @(negedge clock);
    #1;
    check("rst phase", 32'(dut.phase), 32'(PCP1));
    check("rst address", 32'(address), 32'd0);
    check("rst data_out", data_out, 32'd0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst cc", 32'(dut.cc_r), 32'd0);
    check("rst p", 32'(dut.p_r), 32'd0);
    @(negedge clock);
    track_wr = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("wait e1 phase", 32'(dut.phase), 32'(PH1));
    check("wait e1 address", 32'(address), 32'd0);
    @(posedge clock);
    #1;
    check("wait e2 phase", 32'(dut.phase), 32'(PH2));
    @(posedge clock);
    #1;
    check("wait e3 phase", 32'(dut.phase), 32'(PCP2));
    check("wait p", 32'(dut.p_r), 32'd1);
    for (int k = 0; k < 4; k++) @(posedge clock);
    #1;
    check("wait hold phase", 32'(dut.phase), 32'(PCP2));
    check("wait hold address", 32'(address), 32'd1);
    track_wr = 1'b0;
    check("wait stray writes", 32'(stray_wr), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset arriving during the execute cycle of a store must block the write.
    load({32'h0, 32'h0, 32'h0, 32'h0, 32'h35100040, 32'h22100007});
    mem[10'h40] = 32'h11111111;
    start_from_reset();
    for (int k = 0; k < 4; k++) @(posedge clock);
    #1;
    check("stw ph2 phase", 32'(dut.phase), 32'(PH2));
    check("stw ph2 wr_en", 32'(wr_en), 32'hF);
    check("stw ph2 address", 32'(address), 32'h40);
    check("stw ph2 data", data_out, 32'h00000007);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort phase", 32'(dut.phase), 32'(PCP1));
    check("abort wr_en", 32'(wr_en), 32'd0);
    check("abort address", 32'(address), 32'd0);
    check("abort data_out", data_out, 32'd0);
    @(posedge clock);
    #1;
    check("abort mem", mem[10'h40], 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// Free-running simulation clock, 50% duty, starting low.
module sigma_clock #(
  parameter int CLK_PERIOD = 10
) (
  output logic clock
);
  initial begin
    clock = 1'b0;
    forever #(CLK_PERIOD / 2) clock = ~clock;
  end
endmodule
